// File: rtl/irq_prio_router.sv
// Priority IRQ router: NUM_SLOTS*NUM_TILE_INT_CH tile requests onto NUM_CPU_INT lines with ack/SVC/EOI per line.
// Latency: req edge -> cpu_int high 2 clk (3 clk with IRQ_PRIO_ROUTER_SYNC_EN, 2-flop req synchronizer).
// Backpressure: none; a line stays in SVC until its EOI, and new requests wait in PEND for an ack.
module irq_prio_router #(
    parameter int NUM_SLOTS       = 4,
    parameter int NUM_TILE_INT_CH = 2,
    parameter int NUM_CPU_INT     = 4,
    parameter int PRIO_W          = 2,
    parameter int CFG_ADDR_WIDTH  = 8,
    parameter int SLOT_IDX_WIDTH  = (NUM_SLOTS <= 1) ? 1 : $clog2(NUM_SLOTS),
    parameter int CH_IDX_WIDTH    = (NUM_TILE_INT_CH <= 1) ? 1 : $clog2(NUM_TILE_INT_CH)
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [NUM_SLOTS*NUM_TILE_INT_CH-1:0] i_tile_int_req,
    input  logic [NUM_CPU_INT-1:0]               i_irq_ack,
    input  logic [NUM_CPU_INT-1:0]               i_irq_eoi,
    output logic [NUM_CPU_INT-1:0]               o_cpu_int,
    output logic [NUM_SLOTS-1:0]                 o_slot_ack,
    output logic                                 o_irq_int_active,
    output logic [SLOT_IDX_WIDTH-1:0]            o_irq_int_slot,
    output logic [CH_IDX_WIDTH-1:0]              o_irq_int_ch,
    input  logic                                 i_cfg_wr_en,
    input  logic                                 i_cfg_rd_en,
    input  logic [CFG_ADDR_WIDTH-1:0]            i_cfg_addr,
    input  logic [31:0]                          i_cfg_wdata,
    output logic [31:0]                          o_cfg_rdata
);
    localparam int NSRC = NUM_SLOTS * NUM_TILE_INT_CH;

    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_SVC} state_t;

    logic [NSRC-1:0]           r_req_q;
    logic [NSRC-1:0]           r_en;
    logic [PRIO_W-1:0]         r_prio [NSRC];
    logic [3:0]                r_cpu  [NSRC];
    state_t                    r_state [NUM_CPU_INT];
    state_t                    w_state_nxt [NUM_CPU_INT];
    logic [SLOT_IDX_WIDTH-1:0] r_svc_slot [NUM_CPU_INT];
    logic [CH_IDX_WIDTH-1:0]   r_svc_ch   [NUM_CPU_INT];
    logic [NUM_SLOTS-1:0]      r_slot_ack;
    logic [NUM_SLOTS-1:0]      w_slot_ack_nxt;
    logic [31:0]               r_rdata;
    logic [31:0]               w_rd_dat;

    logic [NUM_CPU_INT-1:0]    w_win_vld;
    logic [PRIO_W-1:0]         w_win_prio [NUM_CPU_INT];
    logic [SLOT_IDX_WIDTH-1:0] w_win_slot [NUM_CPU_INT];
    logic [CH_IDX_WIDTH-1:0]   w_win_ch   [NUM_CPU_INT];

    logic                      w_svc_hit;
    logic                      w_pend_hit;
    logic [SLOT_IDX_WIDTH-1:0] w_svc_slot;
    logic [CH_IDX_WIDTH-1:0]   w_svc_ch;
    logic [SLOT_IDX_WIDTH-1:0] w_pend_slot;
    logic [CH_IDX_WIDTH-1:0]   w_pend_ch;

    logic w_unused;
    assign w_unused = &{1'b0, i_cfg_wdata};

`ifdef IRQ_PRIO_ROUTER_SYNC_EN
    logic [NSRC-1:0] r_req_meta;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_req_meta <= '0;
            r_req_q    <= '0;
        end else begin
            r_req_meta <= i_tile_int_req;
            r_req_q    <= r_req_meta;
        end
    end
`else
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_req_q <= '0;
        end else begin
            r_req_q <= i_tile_int_req;
        end
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_en <= '0;
            for (int s = 0; s < NSRC; s++) begin
                r_prio[s] <= '0;
                r_cpu[s]  <= '0;
            end
        end else if (i_cfg_wr_en) begin
            for (int s = 0; s < NSRC; s++) begin
                if (i_cfg_addr == CFG_ADDR_WIDTH'(s)) begin
                    r_en[s]   <= i_cfg_wdata[7];
                    r_prio[s] <= i_cfg_wdata[4 +: PRIO_W];
                    r_cpu[s]  <= i_cfg_wdata[3:0];
                end
            end
        end
    end

    // Strict '>' keeps the lowest source index on a priority tie.
    always_comb begin
        for (int l = 0; l < NUM_CPU_INT; l++) begin
            w_win_vld[l]  = 1'b0;
            w_win_prio[l] = '0;
            w_win_slot[l] = '0;
            w_win_ch[l]   = '0;
            for (int s = 0; s < NSRC; s++) begin
                if (r_req_q[s] && r_en[s] && (r_cpu[s] == 4'(l)) &&
                    (!w_win_vld[l] || (r_prio[s] > w_win_prio[l]))) begin
                    w_win_vld[l]  = 1'b1;
                    w_win_prio[l] = r_prio[s];
                    w_win_slot[l] = SLOT_IDX_WIDTH'(s / NUM_TILE_INT_CH);
                    w_win_ch[l]   = CH_IDX_WIDTH'(s % NUM_TILE_INT_CH);
                end
            end
        end
    end

    always_comb begin
        w_slot_ack_nxt = '0;
        for (int l = 0; l < NUM_CPU_INT; l++) begin
            w_state_nxt[l] = r_state[l];
            case (r_state[l])
                ST_IDLE: if (w_win_vld[l]) w_state_nxt[l] = ST_PEND;
                ST_PEND: begin
                    if (!w_win_vld[l]) begin
                        w_state_nxt[l] = ST_IDLE;
                    end else if (i_irq_ack[l]) begin
                        w_state_nxt[l] = ST_SVC;
                        w_slot_ack_nxt[w_win_slot[l]] = 1'b1;
                    end
                end
                ST_SVC:  if (i_irq_eoi[l]) w_state_nxt[l] = ST_IDLE;
                default: w_state_nxt[l] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_slot_ack <= '0;
            for (int l = 0; l < NUM_CPU_INT; l++) begin
                r_state[l]    <= ST_IDLE;
                r_svc_slot[l] <= '0;
                r_svc_ch[l]   <= '0;
            end
        end else begin
            r_slot_ack <= w_slot_ack_nxt;
            for (int l = 0; l < NUM_CPU_INT; l++) begin
                r_state[l] <= w_state_nxt[l];
                if (r_state[l] == ST_PEND && w_win_vld[l] && i_irq_ack[l]) begin
                    r_svc_slot[l] <= w_win_slot[l];
                    r_svc_ch[l]   <= w_win_ch[l];
                end
            end
        end
    end

    // A line in service owns the vector fetch ahead of any merely pending line.
    always_comb begin
        o_cpu_int        = '0;
        o_irq_int_active = 1'b0;
        w_svc_hit        = 1'b0;
        w_pend_hit       = 1'b0;
        w_svc_slot       = '0;
        w_svc_ch         = '0;
        w_pend_slot      = '0;
        w_pend_ch        = '0;
        for (int l = 0; l < NUM_CPU_INT; l++) begin
            o_cpu_int[l] = (r_state[l] == ST_PEND);
            if (r_state[l] != ST_IDLE) o_irq_int_active = 1'b1;
            if (r_state[l] == ST_SVC && !w_svc_hit) begin
                w_svc_hit  = 1'b1;
                w_svc_slot = r_svc_slot[l];
                w_svc_ch   = r_svc_ch[l];
            end
            if (r_state[l] == ST_PEND && !w_pend_hit) begin
                w_pend_hit  = 1'b1;
                w_pend_slot = w_win_slot[l];
                w_pend_ch   = w_win_ch[l];
            end
        end
        o_irq_int_slot = w_svc_hit ? w_svc_slot : (w_pend_hit ? w_pend_slot : '0);
        o_irq_int_ch   = w_svc_hit ? w_svc_ch   : (w_pend_hit ? w_pend_ch   : '0);
    end

    assign o_slot_ack = r_slot_ack;

    always_comb begin
        w_rd_dat = '0;
        if (i_cfg_addr == {CFG_ADDR_WIDTH{1'b1}}) begin
            w_rd_dat = 32'(r_req_q & r_en);
        end else begin
            for (int s = 0; s < NSRC; s++) begin
                if (i_cfg_addr == CFG_ADDR_WIDTH'(s)) begin
                    w_rd_dat[7]            = r_en[s];
                    w_rd_dat[4 +: PRIO_W]  = r_prio[s];
                    w_rd_dat[3:0]          = r_cpu[s];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_cfg_rd_en) begin
            r_rdata <= w_rd_dat;
        end
    end

    assign o_cfg_rdata = r_rdata;

endmodule

// File: tb/tb_irq_prio_router.sv
// Directed bench for irq_prio_router: reset, priority, handshake, withdrawal, steering, config.
module tb_irq_prio_router;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  tile_int_req = '0;
    logic [3:0]  irq_ack = '0;
    logic [3:0]  irq_eoi = '0;
    logic [3:0]  cpu_int;
    logic [3:0]  slot_ack;
    logic        int_active;
    logic [1:0]  int_slot;
    logic [0:0]  int_ch;
    logic        cfg_wr_en = 1'b0;
    logic        cfg_rd_en = 1'b0;
    logic [7:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] cfg_rdata;

    int total = 0;
    int bad   = 0;

`ifdef IRQ_PRIO_ROUTER_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    irq_prio_router dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_tile_int_req   (tile_int_req),
        .i_irq_ack        (irq_ack),
        .i_irq_eoi        (irq_eoi),
        .o_cpu_int        (cpu_int),
        .o_slot_ack       (slot_ack),
        .o_irq_int_active (int_active),
        .o_irq_int_slot   (int_slot),
        .o_irq_int_ch     (int_ch),
        .i_cfg_wr_en      (cfg_wr_en),
        .i_cfg_rd_en      (cfg_rd_en),
        .i_cfg_addr       (cfg_addr),
        .i_cfg_wdata      (cfg_wdata),
        .o_cfg_rdata      (cfg_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tile_int_req = '0; irq_ack = '0; irq_eoi = '0;
        cfg_wr_en = 1'b0; cfg_rd_en = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
        cfg_wr_en = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick(1);
        cfg_wr_en = 1'b0; cfg_wdata = '0;
    endtask

    task automatic cfg_read(input logic [7:0] a);
        cfg_rd_en = 1'b1; cfg_addr = a;
        tick(1);
        cfg_rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(1);
        total++;
        if ({cpu_int, slot_ack, int_active, int_slot, int_ch, cfg_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got cpu=%b sack=%b act=%b slot=%0d ch=%0d rd=%h want all 0",
                     cpu_int, slot_ack, int_active, int_slot, int_ch, cfg_rdata);
        end
        rst = 1'b0;
        tick(1);
        cfg_write(8'd5, 32'h90);
        tile_int_req = 8'b0010_0000;
        tick(LAT);
        total++;
        if (cpu_int !== 4'b0001) begin
            bad++; $display("FAIL t1_pend cpu_int=%b want 0001", cpu_int);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (cpu_int !== 4'b0000 || slot_ack !== 4'b0000) begin
            bad++; $display("FAIL t1_async_rst cpu_int=%b slot_ack=%b want 0000/0000", cpu_int, slot_ack);
        end
        tick(1);
        rst = 1'b0;
        tick(5);
        total++;
        if (cpu_int !== 4'b0000 || int_active !== 1'b0) begin
            bad++; $display("FAIL t1_table_cleared cpu_int=%b act=%b want 0000/0", cpu_int, int_active);
        end
    endtask

    task automatic test_priority();
        do_reset();
        cfg_write(8'd4, 32'h90);   // src(2,0) prio1 line0
        cfg_write(8'd7, 32'hB0);   // src(3,1) prio3 line0
        cfg_write(8'd2, 32'hB0);   // src(1,0) prio3 line0
        tile_int_req = 8'b1001_0100;
        tick(LAT);
        total++;
        if (cpu_int !== 4'b0001 || int_slot !== 2'd1 || int_ch !== 1'b0) begin
            bad++; $display("FAIL t2_pend_vec cpu=%b slot=%0d ch=%0d want 0001/1/0", cpu_int, int_slot, int_ch);
        end
        irq_ack = 4'b0001;
        tick(1);
        irq_ack = '0;
        total++;
        if (slot_ack !== 4'b0010 || int_slot !== 2'd1 || int_ch !== 1'b0 || cpu_int !== 4'b0000) begin
            bad++; $display("FAIL t2_ack sack=%b slot=%0d ch=%0d cpu=%b want 0010/1/0/0000",
                            slot_ack, int_slot, int_ch, cpu_int);
        end
    endtask

    task automatic test_handshake();
        do_reset();
        cfg_write(8'd4, 32'h90);
        tile_int_req = 8'b0001_0000;
        tick(LAT - 1);
        total++;
        if (cpu_int !== 4'b0000) begin
            bad++; $display("FAIL t3_early cpu_int=%b want 0000", cpu_int);
        end
        tick(1);
        total++;
        if (cpu_int !== 4'b0001) begin
            bad++; $display("FAIL t3_latency cpu_int=%b want 0001", cpu_int);
        end
        irq_ack = 4'b0001;
        tick(1);
        irq_ack = '0;
        total++;
        if (cpu_int !== 4'b0000 || slot_ack !== 4'b0100) begin
            bad++; $display("FAIL t3_ack cpu=%b sack=%b want 0000/0100", cpu_int, slot_ack);
        end
        tick(1);
        total++;
        if (slot_ack !== 4'b0000 || int_active !== 1'b1) begin
            bad++; $display("FAIL t3_pulse_width sack=%b act=%b want 0000/1", slot_ack, int_active);
        end
        irq_ack = 4'b0001;   // ack while in SVC must be ignored
        tick(1);
        irq_ack = '0;
        tick(2);
        total++;
        if (int_active !== 1'b1 || cpu_int !== 4'b0000 || slot_ack !== 4'b0000) begin
            bad++; $display("FAIL t3_hold act=%b cpu=%b sack=%b want 1/0000/0000", int_active, cpu_int, slot_ack);
        end
        irq_eoi = 4'b0001;
        tick(1);
        irq_eoi = '0;
        total++;
        if (int_active !== 1'b0) begin
            bad++; $display("FAIL t3_eoi act=%b want 0", int_active);
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        cfg_write(8'd4, 32'h90);
        tile_int_req = 8'b0001_0000;
        tick(LAT);
        tile_int_req = '0;
        tick(LAT);
        total++;
        if (cpu_int !== 4'b0000 || int_active !== 1'b0 || int_slot !== 2'd0 || int_ch !== 1'b0) begin
            bad++; $display("FAIL t4_pend_drop cpu=%b act=%b slot=%0d ch=%0d want 0000/0/0/0",
                            cpu_int, int_active, int_slot, int_ch);
        end
        tile_int_req = 8'b0001_0000;
        tick(LAT);
        irq_ack = 4'b0001;
        tick(1);
        irq_ack = '0;
        tile_int_req = '0;
        tick(4);
        total++;
        if (int_active !== 1'b1 || int_slot !== 2'd2 || cpu_int !== 4'b0000) begin
            bad++; $display("FAIL t4_svc_drop act=%b slot=%0d cpu=%b want 1/2/0000", int_active, int_slot, cpu_int);
        end
        tile_int_req = 8'b0001_0000;
        tick(LAT);
        irq_eoi = 4'b0001;
        tick(1);
        irq_eoi = '0;
        tick(1);
        total++;
        if (cpu_int !== 4'b0001) begin
            bad++; $display("FAIL t4_rearm cpu_int=%b want 0001", cpu_int);
        end
    endtask

    task automatic test_steering();
        do_reset();
        cfg_write(8'd2, 32'h90);   // src(1,0) -> line0
        cfg_write(8'd6, 32'h91);   // src(3,0) -> line1
        tile_int_req = 8'b0100_0100;
        tick(LAT);
        total++;
        if (cpu_int !== 4'b0011 || int_slot !== 2'd1) begin
            bad++; $display("FAIL t5_both_pend cpu=%b slot=%0d want 0011/1", cpu_int, int_slot);
        end
        irq_ack = 4'b0001;
        tick(1);
        irq_ack = '0;
        tile_int_req = 8'b0100_0000;
        tick(LAT);
        total++;
        if (cpu_int !== 4'b0010 || int_slot !== 2'd1 || slot_ack !== 4'b0000) begin
            bad++; $display("FAIL t5_svc_wins cpu=%b slot=%0d sack=%b want 0010/1/0000", cpu_int, int_slot, slot_ack);
        end
        irq_eoi = 4'b0001;
        tick(1);
        irq_eoi = '0;
        total++;
        if (int_slot !== 2'd3 || int_active !== 1'b1) begin
            bad++; $display("FAIL t5_after_eoi slot=%0d act=%b want 3/1", int_slot, int_active);
        end
        irq_ack = 4'b0011;   // line0 is idle, only line1 acks
        tick(1);
        irq_ack = '0;
        total++;
        if (slot_ack !== 4'b1000 || int_slot !== 2'd3) begin
            bad++; $display("FAIL t5_line1_ack sack=%b slot=%0d want 1000/3", slot_ack, int_slot);
        end
    endtask

    task automatic test_config();
        do_reset();
        cfg_write(8'd3, 32'h0000_00A2);
        cfg_read(8'd3);
        total++;
        if (cfg_rdata !== 32'h0000_00A2) begin
            bad++; $display("FAIL t6_readback rdata=%h want 000000a2", cfg_rdata);
        end
        tile_int_req = 8'b0000_1000;
        tick(LAT);
        cfg_read(8'hFF);
        total++;
        if (cfg_rdata !== 32'h0000_0008) begin
            bad++; $display("FAIL t6_status rdata=%h want 00000008", cfg_rdata);
        end
        total++;
        if (cpu_int !== 4'b0100) begin
            bad++; $display("FAIL t6_route_line2 cpu=%b want 0100", cpu_int);
        end
        cfg_write(8'hFF, 32'h0000_0000);
        cfg_read(8'd3);
        total++;
        if (cfg_rdata !== 32'h0000_00A2) begin
            bad++; $display("FAIL t6_status_wr_ignored rdata=%h want 000000a2", cfg_rdata);
        end
        cfg_read(8'h10);
        total++;
        if (cfg_rdata !== 32'h0) begin
            bad++; $display("FAIL t6_unmapped_read rdata=%h want 00000000", cfg_rdata);
        end
        tick(3);
        total++;
        if (cfg_rdata !== 32'h0) begin
            bad++; $display("FAIL t6_rdata_hold rdata=%h want 00000000", cfg_rdata);
        end
        cfg_write(8'd0, 32'h0000_0085);   // enabled but CPU line 5 does not exist
        tile_int_req = 8'b0000_0001;
        tick(LAT + 2);
        total++;
        if (cpu_int !== 4'b0000) begin
            bad++; $display("FAIL t6_invalid_cpu cpu=%b want 0000", cpu_int);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_handshake();
        test_withdraw();
        test_steering();
        test_config();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
